bin2seg_display: RTL and testbench
==================================

# bin2seg_display

Sequential value-to-segment formatter that feeds the 8-digit LED multiplexer. It accepts a 32-bit value on a start pulse and converts it to eight active-low seven-segment patterns (`LED0` = leftmost … `LED7` = rightmost). Conversion is either hex (direct nibbles) or decimal (iterative shift-add-3 binary-to-BCD), with optional leading-zero blanking and a per-digit decimal-point mask. Outputs are registered and held stable between conversions so the multiplexer can scan them freely.

## Interface
- No parameters; digit count fixed at 8, input width fixed at 32.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a conversion; sampled only in IDLE.
- `value` in 32: number to display; captured on accepted start.
- `dec_mode` in 1: 1 = decimal, 0 = hex; captured on accepted start.
- `blank_lz` in 1: 1 = blank leading zeros; captured on accepted start.
- `dp_mask` in 8: bit i lights the DP of `LEDi`; captured on accepted start.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse, asserted in the first cycle new LEDs are visible.
- `overflow` out 1: decimal value exceeded 99_999_999; held until next accepted start.
- `LED0`..`LED7` out 8 each: segment patterns, active-low, bit0 = a … bit6 = g, bit7 = dp.

## Operation
- States: IDLE, CONV, ENCODE.
- IDLE, `start`=1:
  - Capture the inputs.
  - `busy`←1, clear `overflow`.
  - hex → ENCODE.
  - decimal and `value` > 99_999_999 → set `overflow`, → ENCODE.
  - otherwise clear the 32-bit BCD register and the iteration counter, → CONV.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. 32 iterations (counter 0..31), then → ENCODE.
- ENCODE: on one edge, load all 8 LED registers, `done`←1, `busy`←0, → IDLE.
- Digit source: hex uses `value[31:28]` for `LED0` … `[3:0]` for `LED7`; decimal uses BCD nibbles in the same order.
- Font (active-low, DP off):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
  - dash BF, blank FF.
- Leading-zero blanking: zero digits left of the most significant nonzero digit become FF. `LED7` is never blanked, so value 0 shows a single "0".
- Overflow: all eight digits show BF; `blank_lz` is ignored.
- DP: after font and blanking, clear bit7 of `LEDi` where `dp_mask[i]`=1. This also applies to blanked digits (pattern 7F).
- `start` while `busy`: ignored, no queuing.
- `start` in the same cycle `done` is high: state is IDLE, so it is accepted.
- `value` and the other inputs may change after capture without effect.

## Timing
- Accepted start edge = E0.
- Decimal: CONV on E1..E32; ENCODE edge E33. `done`=1 and new LEDs are visible during the cycle after E33. `busy`=1 after E0 through E32.
- Hex and overflow: ENCODE edge E1. `done` and new LEDs are visible after E1.
- LED outputs change only on the ENCODE edge or on reset.
- Reset values (`rst_n`=0 at any edge): state IDLE, `busy`=0, `done`=0, `overflow`=0, all LEDs FF.
- Reset mid-conversion aborts the conversion; no `done` is produced.

## Structure
- Package `bin2seg_pkg` holds:
  - the state enum;
  - constants `SEG_BLANK` (8'hFF) and `SEG_DASH` (8'hBF);
  - the 16-entry font constants.
- Sub-module `hex7seg`: combinational 4-bit → 7-segment font lookup, active-low, DP bit forced to 1. It is instantiated 8 times.
- All other logic lives in `bin2seg_display`: FSM, capture registers, BCD datapath, blanking and DP logic, LED registers.

## Test plan
- Decimal 12_345_678, `blank_lz`=1, `dp_mask`=0 → LED0..7 = F9 A4 B0 99 92 82 F8 80; `done` after E33; `busy` high for 33 cycles.
- Decimal 42, `blank_lz`=1 → LED0..5 = FF, LED6 = 99, LED7 = A4. Decimal 0, `blank_lz`=1 → LED0..6 = FF, LED7 = C0. Decimal 42, `blank_lz`=0 → LED0..5 = C0.
- Hex 32'hDEADBEEF, `dp_mask`=8'h01 → LED0..7 = 21 86 88 A1 83 86 86 8E; `done` after E1.
- Decimal 100_000_000 → all LEDs BF, `overflow`=1, `done` after E1. A following decimal 7 → `overflow`=0, LED7 = F8.
- Decimal start, `rst_n`=0 at E10 → LEDs FF, `busy`=0, no `done`. A new start after reset → correct result 33 cycles later.
- `start` pulsed every cycle during a decimal conversion → exactly one `done`, with the first captured value displayed.

Source files
------------

// File: rtl/bin2seg_pkg.sv
// Shared types and constants for the 8-digit value-to-segment formatter.
// Segment patterns are active-low with bit0 = a ... bit6 = g, bit7 = dp.
package bin2seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ENCODE
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [31:0] DEC_MAX = 32'd99_999_999;

  // Index n holds the glyph for nibble n (0 at the right end of the literal).
  localparam logic [15:0][7:0] FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-glyph lookup; the decimal point is always off here
// and is applied later by the display block.
module hex7seg
  import bin2seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = {1'b1, FONT[digit][6:0]};

endmodule

// File: rtl/bin2seg_display.sv
// Converts a captured 32-bit value to eight registered seven-segment patterns,
// either as hex nibbles or via a 32-step shift-add-3 binary-to-BCD conversion.
module bin2seg_display
  import bin2seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        dec_mode,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  LED0,
  output logic [7:0]  LED1,
  output logic [7:0]  LED2,
  output logic [7:0]  LED3,
  output logic [7:0]  LED4,
  output logic [7:0]  LED5,
  output logic [7:0]  LED6,
  output logic [7:0]  LED7
);

  state_t      state, state_next;
  logic [31:0] value_q;
  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [31:0] bcd_adj;
  logic [4:0]  iter_q;
  logic        dec_q;
  logic        blank_q;
  logic [7:0]  dp_q;
  logic [7:0]  led_q    [8];
  logic [7:0]  led_next [8];
  logic [7:0]  font_seg [8];
  logic [3:0]  digit    [8];
  logic        leading;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!dec_mode || value > DEC_MAX) state_next = ENCODE;
          else                              state_next = CONV;
        end
      end
      CONV:    if (iter_q == 5'd31) state_next = ENCODE;
      ENCODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-add-3 correction: any BCD nibble of 5 or more would exceed 9 after the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q  <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      dec_q    <= 1'b0;
      blank_q  <= 1'b0;
      dp_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 8; i++) led_q[i] <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            value_q  <= value;
            bin_q    <= value;
            dec_q    <= dec_mode;
            blank_q  <= blank_lz;
            dp_q     <= dp_mask;
            busy     <= 1'b1;
            overflow <= dec_mode && (value > DEC_MAX);
            bcd_q    <= '0;
            iter_q   <= '0;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[30:0], bin_q, 1'b0};
          iter_q         <= iter_q + 5'd1;
        end
        ENCODE: begin
          for (int i = 0; i < 8; i++) led_q[i] <= led_next[i];
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (dec_q) digit[i] = bcd_q[28 - 4*i +: 4];
      else       digit[i] = value_q[28 - 4*i +: 4];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_font
    hex7seg u_font (
      .digit (digit[g]),
      .seg   (font_seg[g])
    );
  end

  // Leftmost digit first; the rightmost digit is never blanked so zero still shows.
  always_comb begin
    leading = 1'b1;
    for (int i = 0; i < 8; i++) begin
      led_next[i] = font_seg[i];
      if (overflow) begin
        led_next[i] = SEG_DASH;
      end else if (blank_q && leading && digit[i] == 4'd0 && i != 7) begin
        led_next[i] = SEG_BLANK;
      end
      if (digit[i] != 4'd0) leading = 1'b0;
      if (dp_q[i]) led_next[i][7] = 1'b0;
    end
  end

  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];
  assign LED3 = led_q[3];
  assign LED4 = led_q[4];
  assign LED5 = led_q[5];
  assign LED6 = led_q[6];
  assign LED7 = led_q[7];

endmodule

// File: tb/tb_bin2seg_display.sv
// Self-checking bench for bin2seg_display: directed cases with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_bin2seg_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        dec_mode;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  led [8];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [7:0] tb_font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: cycles left until the display updates, and what it will show.
  int          m_count = 0;
  logic        m_done  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [63:0] m_leds  = '1;
  logic [63:0] m_pend  = '1;

  always #5 clk = ~clk;

  bin2seg_display dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .LED0     (led[0]),
    .LED1     (led[1]),
    .LED2     (led[2]),
    .LED3     (led[3]),
    .LED4     (led[4]),
    .LED5     (led[5]),
    .LED6     (led[6]),
    .LED7     (led[7])
  );

  // Expected glyphs packed with LED0 in the top byte.
  function automatic logic [63:0] model_leds(input logic [31:0] v, input logic dec,
                                             input logic blank, input logic [7:0] dp);
    logic [63:0]     r;
    logic [7:0]      s;
    longint unsigned vv;
    longint unsigned p;
    int              d;
    bit              seen;
    bit              ovf;
    vv   = longint'(v);
    ovf  = dec && (v > 32'd99_999_999);
    seen = 0;
    r    = '0;
    for (int i = 0; i < 8; i++) begin
      if (dec) begin
        p = 1;
        for (int j = 0; j < 7 - i; j++) p = p * 10;
        d = int'((vv / p) % 10);
      end else begin
        d = int'((vv >> (4 * (7 - i))) & 15);
      end
      if (ovf)                                   s = 8'hBF;
      else if (blank && !seen && d == 0 && i < 7) s = 8'hFF;
      else                                       s = tb_font[d];
      if (d != 0) seen = 1;
      if (dp[i]) s[7] = 1'b0;
      r[63 - 8*i -: 8] = s;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkLeds(input string name, input logic [63:0] exp);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_led%0d", name, i), {24'd0, led[i]}, {24'd0, exp[63 - 8*i -: 8]});
  endtask

  // Pulses start for one cycle from a falling edge and waits (bounded) for done.
  task automatic applyStimulus(input logic [31:0] v, input logic dec, input logic blank,
                               input logic [7:0] dp, output int lat, output int busy_cycles);
    value    = v;
    dec_mode = dec;
    blank_lz = blank;
    dp_mask  = dp;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_count = 0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_leds  = '1;
    end else begin
      m_done = 1'b0;
      if (m_count > 0) begin
        m_count--;
        if (m_count == 0) begin
          m_leds = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend  = model_leds(value, dec_mode, blank_lz, dp_mask);
        m_ovf   = dec_mode && (value > 32'd99_999_999);
        m_count = (dec_mode && !m_ovf) ? 33 : 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, m_count > 0});
      checkOutput("done", {31'd0, done}, {31'd0, m_done});
      checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("led%0d", i), {24'd0, led[i]}, {24'd0, m_leds[63 - 8*i -: 8]});
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int bcyc;
    int ndone;

    rst_n    = 1'b0;
    start    = 1'b0;
    value    = '0;
    dec_mode = 1'b0;
    blank_lz = 1'b0;
    dp_mask  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkLeds("rst", 64'hFFFF_FFFF_FFFF_FFFF);
    chk_en = 1;
    rst_n  = 1'b1;
    @(negedge clk);

    applyStimulus(32'd12_345_678, 1'b1, 1'b1, 8'h00, lat, bcyc);
    checkOutput("dec_latency", lat, 33);
    checkOutput("dec_busy_cycles", bcyc, 33);
    checkLeds("dec12345678", 64'hF9A4_B099_9282_F880);

    applyStimulus(32'd42, 1'b1, 1'b1, 8'h00, lat, bcyc);
    checkLeds("dec42_blank", 64'hFFFF_FFFF_FFFF_99A4);

    applyStimulus(32'd0, 1'b1, 1'b1, 8'h00, lat, bcyc);
    checkLeds("dec0_blank", 64'hFFFF_FFFF_FFFF_FFC0);

    applyStimulus(32'd42, 1'b1, 1'b0, 8'h00, lat, bcyc);
    checkLeds("dec42_noblank", 64'hC0C0_C0C0_C0C0_99A4);

    applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0, 8'h01, lat, bcyc);
    checkOutput("hex_latency", lat, 1);
    checkLeds("hex_deadbeef", 64'h2186_88A1_8386_868E);

    applyStimulus(32'd100_000_000, 1'b1, 1'b1, 8'h00, lat, bcyc);
    checkOutput("ovf_latency", lat, 1);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkLeds("ovf", 64'hBFBF_BFBF_BFBF_BFBF);

    applyStimulus(32'd7, 1'b1, 1'b1, 8'h00, lat, bcyc);
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);
    checkOutput("dec7_led7", {24'd0, led[7]}, 32'h0000_00F8);

    // Reset lands on the tenth edge after the accepted start.
    value    = 32'd12_345_678;
    dec_mode = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkLeds("abort", 64'hFFFF_FFFF_FFFF_FFFF);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checkOutput("abort_no_done", ndone, 0);

    applyStimulus(32'd87_654_321, 1'b1, 1'b0, 8'h00, lat, bcyc);
    checkOutput("after_abort_latency", lat, 33);
    checkLeds("after_abort", 64'h80F8_8292_99B0_A4F9);

    // Hammer start throughout a decimal conversion with changing inputs.
    value    = 32'd24_681_357;
    dec_mode = 1'b1;
    blank_lz = 1'b0;
    dp_mask  = 8'hA0;
    start    = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      value    = $urandom;
      dec_mode = 1'($urandom);
      blank_lz = 1'($urandom);
      dp_mask  = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checkOutput("hammer_one_done", ndone, 1);
    checkLeds("hammer", 64'hA499_8280_F930_9278);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: value = $urandom_range(0, 999);
        1: value = $urandom;
        2: value = $urandom_range(0, 99_999_999);
        default: begin
          case ($urandom_range(0, 3))
            0: value = 32'd0;
            1: value = 32'd99_999_999;
            2: value = 32'd100_000_000;
            default: value = 32'hFFFF_FFFF;
          endcase
        end
      endcase
      dec_mode = ($urandom_range(0, 2) != 0);
      blank_lz = 1'($urandom);
      dp_mask  = 8'($urandom);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
